// File: rtl/renkon_pkg.sv
// renkon_pkg
//   Shared sizing, state encoding and address helper for the serialiser
//   stage that sits behind the pooling controller.
//   CORE     lanes delivered per pooled valid (power of two, >= 2)
//   MEMSIZE  output feature memory address width
//   LWIDTH   layer-size / pixel-counter width (must not exceed MEMSIZE)
//   DWIDTH   width of the ctrl_bus delay field
package renkon_pkg;

  localparam int CORE    = 8;
  localparam int MEMSIZE = 12;
  localparam int LWIDTH  = 10;
  localparam int DWIDTH  = 4;
  localparam int SEL_W   = $clog2(CORE);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CORE - 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_ACTIVE = 2'd1,
    S_SERIAL = 2'd2,
    S_DONE   = 2'd3
  } serial_state_t;

  // Lane-0 address of a pixel; the sum wraps modulo 2^MEMSIZE.
  function automatic logic [MEMSIZE-1:0] lane0_addr(
    input logic [MEMSIZE-1:0] base,
    input logic [LWIDTH-1:0]  pix
  );
    return base + MEMSIZE'(pix);
  endfunction

  // Pixel count widened to the size register for the end-of-layer check.
  function automatic logic count_mismatch(
    input logic [LWIDTH-1:0]  pix,
    input logic [MEMSIZE-1:0] size
  );
    return MEMSIZE'(pix) != size;
  endfunction

endpackage

// File: rtl/renkon_ctrl_bus.sv
// ctrl_bus
//   Frame control handshake between pipeline stages.
//   start  first beat of a layer
//   valid  one pooled pixel (CORE lanes) is presented
//   stop   layer stream ends
//   delay  pipeline alignment hint (not used by the serialiser)
//   ready  downstream can take a valid this cycle
interface ctrl_bus;
  import renkon_pkg::*;

  logic              start;
  logic              valid;
  logic              stop;
  logic [DWIDTH-1:0] delay;
  logic              ready;

  modport master (output start, output valid, output stop, output delay, input ready);
  modport slave  (input start, input valid, input stop, input delay, output ready);

endinterface

// File: rtl/renkon_ctrl_serial.sv
// renkon_ctrl_serial
//   Turns each pooled valid (CORE lane results in parallel) into CORE
//   single-word writes to the output feature memory, one lane per cycle.
//   Lane l of pixel p lands at base + l*size + p (mod 2^MEMSIZE).
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_WAIT   | idle, waiting for in_ctrl.start
//   S_ACTIVE | layer open, no pixel in flight, waiting for valid or stop
//   S_SERIAL | writing lanes 0..CORE-1 of the captured pixel
//   S_DONE   | one-cycle completion pulse, then back to S_WAIT
//
// Ports
//   clk          clock, rising edge
//   xrst         asynchronous active-high reset
//   _out_base    lane-0 / pixel-0 base address, latched on start
//   _out_size    pixels per output map (lane stride), latched on start
//   in_ctrl      ctrl_bus slave: start/valid/stop/delay in, ready out
//   serial_oe    datapath captures all lanes into its holding register
//   serial_sel   lane mux select for the current write
//   serial_we    output memory write enable
//   serial_addr  output memory write address
//   serial_done  single-cycle pulse when the layer is fully written
//   serial_err   sticky overrun / pixel-count mismatch flag
module renkon_ctrl_serial
  import renkon_pkg::*;
(
  input  logic               clk,
  input  logic               xrst,
  input  logic [MEMSIZE-1:0] _out_base,
  input  logic [MEMSIZE-1:0] _out_size,
  ctrl_bus.slave             in_ctrl,
  output logic               serial_oe,
  output logic [SEL_W-1:0]   serial_sel,
  output logic               serial_we,
  output logic [MEMSIZE-1:0] serial_addr,
  output logic               serial_done,
  output logic               serial_err
);

  serial_state_t      state;
  logic [SEL_W-1:0]   sel;
  logic [LWIDTH-1:0]  pix;
  logic [MEMSIZE-1:0] base_q;
  logic [MEMSIZE-1:0] size_q;
  logic [MEMSIZE-1:0] lane_addr;
  logic               stop_seen;
  logic               err;

  logic               last_lane;
  logic               ready;
  logic               accept;
  logic               overrun;
  logic [LWIDTH-1:0]  pix_inc;

  // The last lane cycle doubles as the slot for a back-to-back pixel, so
  // ready is high there and a pixel can follow with no bubble in we.
  assign last_lane = (state == S_SERIAL) && (sel == SEL_LAST);
  assign ready     = (state != S_SERIAL) || (sel == SEL_LAST);
  assign accept    = in_ctrl.valid && ((state == S_ACTIVE) || last_lane);
  assign overrun   = in_ctrl.valid && !ready;
  assign pix_inc   = pix + LWIDTH'(1);

  assign in_ctrl.ready = ready;

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state     <= S_WAIT;
      sel       <= '0;
      pix       <= '0;
      base_q    <= '0;
      size_q    <= '0;
      lane_addr <= '0;
      stop_seen <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (overrun) begin
        err <= 1'b1;
      end

      case (state)
        S_WAIT: begin
          if (in_ctrl.start) begin
            base_q    <= _out_base;
            size_q    <= _out_size;
            pix       <= '0;
            stop_seen <= 1'b0;
            err       <= 1'b0;
            state     <= S_ACTIVE;
          end
        end

        S_ACTIVE: begin
          if (in_ctrl.valid) begin
            sel       <= '0;
            lane_addr <= lane0_addr(base_q, pix);
            stop_seen <= stop_seen | in_ctrl.stop;
            state     <= S_SERIAL;
          end else if (in_ctrl.stop || stop_seen) begin
            if (count_mismatch(pix, size_q)) begin
              err <= 1'b1;
            end
            state <= S_DONE;
          end
        end

        S_SERIAL: begin
          if (sel != SEL_LAST) begin
            sel       <= sel + SEL_W'(1);
            lane_addr <= lane_addr + size_q;
            if (in_ctrl.stop) begin
              stop_seen <= 1'b1;
            end
          end else begin
            pix <= pix_inc;
            if (in_ctrl.valid) begin
              sel       <= '0;
              lane_addr <= lane0_addr(base_q, pix_inc);
              stop_seen <= stop_seen | in_ctrl.stop;
            end else if (stop_seen || in_ctrl.stop) begin
              // stop on the final lane cycle counts as seen for this pixel
              if (count_mismatch(pix_inc, size_q)) begin
                err <= 1'b1;
              end
              state <= S_DONE;
            end else begin
              state <= S_ACTIVE;
            end
          end
        end

        S_DONE: begin
          state <= S_WAIT;
        end

        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

  assign serial_oe   = accept;
  assign serial_sel  = sel;
  assign serial_we   = (state == S_SERIAL);
  assign serial_addr = lane_addr;
  assign serial_done = (state == S_DONE);
  assign serial_err  = err;

endmodule
